icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

- Miss-handling sequencer for the direct-mapped instruction cache.
- Detects a fetch miss, stalls the fetch stage and requests the missing 512-bit block from memory.
- Assembles the block from MEM_DATA_W-wide beats, then writes it into the cache with a one-cycle write strobe.
- Sits between the fetch stage, the instruction cache and the memory/bus interface, and owns the cache's address input.

## Interface
- ADDR_WIDTH, 64: fetch/memory address width.
- BLOCK_WIDTH, 512: cache block width in bits.
- MEM_DATA_W, 64: memory beat width; BEAT_COUNT = BLOCK_WIDTH/MEM_DATA_W (8).
- TIMEOUT_CYCLES, 1024: refill watchdog limit (used only with the macro).
- clk  in  1  clock; all state changes on the rising edge.
- arstn  in  1  reset, synchronous, active-low.
- i_fetch_req  in  1  fetch stage presents a valid address this cycle.
- i_instr_addr  in  ADDR_WIDTH  fetch address.
- i_hit  in  1  cache hit for o_cache_addr.
- i_instr_addr_ma  in  1  cache's misaligned-address flag.
- o_stall  out  1  fetch must hold its address.
- o_cache_addr  out  ADDR_WIDTH  address driven to the cache.
- o_cache_write_en  out  1  one-cycle block write strobe.
- o_cache_block  out  BLOCK_WIDTH  assembled block.
- o_mem_req  out  1  block read request valid.
- o_mem_addr  out  ADDR_WIDTH  block-aligned request address (low 6 bits zero).
- i_mem_req_ready  in  1  memory accepts the request.
- i_mem_data_valid  in  1  beat valid.
- i_mem_data  in  MEM_DATA_W  beat data.
- o_bus_err  out  1  refill timeout pulse.

## Operation
- FSM states: IDLE, REQ, FILL, WRITE.
- **IDLE**
  - o_cache_addr = i_instr_addr.
  - On i_fetch_req & ~i_hit & ~i_instr_addr_ma: latch miss_addr = {i_instr_addr[ADDR_WIDTH-1:6], 6'b0} and go to REQ.
  - A misaligned miss never starts a refill; the exception belongs to the pipeline.
- **REQ**
  - o_mem_req = 1 and o_mem_addr = miss_addr, both held stable until i_mem_req_ready.
  - On i_mem_req_ready: clear beat_cnt and go to FILL.
- **FILL**
  - Each i_mem_data_valid writes i_mem_data into buffer[beat_cnt*MEM_DATA_W +: MEM_DATA_W] and increments beat_cnt.
  - The first beat is the least-significant word.
  - The beat with beat_cnt == BEAT_COUNT-1 moves the FSM to WRITE.
  - Cycles without valid keep the state.
- **WRITE**
  - o_cache_write_en = 1 for exactly one cycle; o_cache_addr = miss_addr; o_cache_block = buffer.
  - Then go to IDLE.
- o_cache_addr = miss_addr in every state except IDLE.
- o_stall = (state != IDLE) | (i_fetch_req & ~i_hit & ~i_instr_addr_ma). It is combinational in IDLE.
- beat_cnt width is $clog2(BEAT_COUNT). It is never allowed to wrap inside FILL.
- i_mem_data_valid outside FILL is ignored.
- i_fetch_req changes during REQ/FILL/WRITE are ignored, since fetch is stalled.

## Timing
- Reset (arstn low at a rising edge): state = IDLE, beat_cnt = 0, o_mem_req = 0, o_cache_write_en = 0, o_bus_err = 0, o_cache_block = 0.
- While in reset, o_stall = 0 and o_cache_addr follows i_instr_addr.
- Reset in any state aborts the refill. No cache write occurs, and a pending memory beat stream is dropped.
- Miss-to-request: 1 cycle (miss detected in IDLE, o_mem_req high the next cycle).
- Minimum refill with ready and valid every cycle:
  - 1 (REQ) + BEAT_COUNT (FILL) + 1 (WRITE) = 10 cycles of stall after the miss cycle.
- The cycle after WRITE, IDLE sees i_hit = 1 for the same address and o_stall drops combinationally.

## Configuration
- ICACHE_REFILL_TIMEOUT_EN defined:
  - A watchdog counter clears on entering REQ and on every accepted handshake/beat, and increments otherwise in REQ/FILL.
  - When it reaches TIMEOUT_CYCLES-1, o_bus_err pulses for one cycle and the FSM goes to IDLE without writing the cache.
- ICACHE_REFILL_TIMEOUT_EN undefined: no counter; o_bus_err is tied 0; the FSM waits indefinitely.

## Structure
- Shared package icache_pkg holds:
  - the state enum icache_refill_state_t (IDLE/REQ/FILL/WRITE);
  - BLOCK_OFFSET_W = 6;
  - default widths.
- The module is a single flat module; no sub-module is needed.
- Beat assembly stays inline as an indexed part-select write.

## Test plan
- Hit: i_fetch_req = 1, i_hit = 1 -> o_stall = 0 and o_mem_req stays 0.
- Miss at 0x1044 with ready and valid every cycle, beats 0x0..0x7:
  - o_mem_addr = 0x1040.
  - o_cache_write_en pulses exactly 10 cycles after the miss cycle.
  - o_cache_block[63:0] = 0, o_cache_block[511:448] = 7.
- Gapped beats (valid every 3rd cycle) plus ready delayed 4 cycles -> the block is identical, and WRITE is entered only after the 8th beat.
- Misaligned miss, address 0x1046 (i_instr_addr_ma = 1) -> no o_mem_req and o_stall = 0.
- arstn low during FILL after 3 beats -> the next cycle is IDLE, o_cache_write_en never asserts, and later beats are ignored.
- With ICACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, ready held low -> o_bus_err pulses once at cycle 16 of REQ, then IDLE with no write.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill sequencer: refill FSM
// state encoding, block offset width and default interface widths.
package icache_pkg;

  localparam int ICACHE_ADDR_W         = 64;
  localparam int ICACHE_BLOCK_W        = 512;
  localparam int ICACHE_MEM_DATA_W     = 64;
  localparam int ICACHE_TIMEOUT_CYCLES = 1024;
  localparam int BLOCK_OFFSET_W        = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    WRITE
  } icache_refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss sequencer: stalls fetch, requests the missing block,
// assembles it from memory beats and writes it into the cache with a one-cycle strobe.
// Optional refill watchdog: define ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = ICACHE_ADDR_W,
  parameter int BLOCK_WIDTH    = ICACHE_BLOCK_W,
  parameter int MEM_DATA_W     = ICACHE_MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = ICACHE_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
  input  logic                   i_hit,
  input  logic                   i_instr_addr_ma,
  output logic                   o_stall,
  output logic [ADDR_WIDTH-1:0]  o_cache_addr,
  output logic                   o_cache_write_en,
  output logic [BLOCK_WIDTH-1:0] o_cache_block,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_data_valid,
  input  logic [MEM_DATA_W-1:0]  i_mem_data,
  output logic                   o_bus_err
);

  localparam int                BEAT_COUNT = BLOCK_WIDTH / MEM_DATA_W;
  localparam int                BEAT_W     = $clog2(BEAT_COUNT);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEAT_COUNT - 1);

  icache_refill_state_t   state;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic [BLOCK_WIDTH-1:0] buffer;
  logic                   miss;
  logic                   timeout;

  // Misaligned fetches are the pipeline's exception, never a refill.
  assign miss = i_fetch_req & ~i_hit & ~i_instr_addr_ma;

  // The fetch stall must rise in the miss cycle itself, so it is decoded, not registered.
  assign o_stall       = arstn & ((state != IDLE) | miss);
  assign o_cache_addr  = (arstn && state != IDLE) ? miss_addr : i_instr_addr;
  assign o_mem_addr    = miss_addr;
  assign o_cache_block = buffer;

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            busy;
  logic            accepted;

  assign busy     = (state == REQ) || (state == FILL);
  assign accepted = ((state == REQ) && i_mem_req_ready) ||
                    ((state == FILL) && i_mem_data_valid);
  // Expiry wins over a handshake in the same cycle, so the error pulse always aborts.
  assign timeout   = busy && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign o_bus_err = timeout;

  always_ff @(posedge clk) begin
    if (!arstn || !busy || accepted || timeout) wd_cnt <= '0;
    else                                        wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign o_bus_err          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      miss_addr        <= '0;
      // NOTE: the block buffer is driven straight onto o_cache_block, so it is
      // cleared on reset like any other visible output rather than left unknown.
      buffer           <= '0;
      o_mem_req        <= 1'b0;
      o_cache_write_en <= 1'b0;
    end else begin
      o_cache_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr <= {i_instr_addr[ADDR_WIDTH-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
            o_mem_req <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            o_mem_req <= 1'b0;
            state     <= IDLE;
          end else if (i_mem_req_ready) begin
            o_mem_req <= 1'b0;
            beat_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (timeout) begin
            state <= IDLE;
          end else if (i_mem_data_valid) begin
            buffer[beat_cnt*MEM_DATA_W +: MEM_DATA_W] <= i_mem_data;
            // The counter stops on the last beat instead of wrapping.
            if (beat_cnt == LAST_BEAT) begin
              o_cache_write_en <= 1'b1;
              state            <= WRITE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl: hit, back-to-back and gapped
// refills, misaligned miss, reset mid-fill and the refill watchdog (ICACHE_REFILL_TIMEOUT_EN).
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         arstn;
  logic         i_fetch_req;
  logic [63:0]  i_instr_addr;
  logic         i_hit;
  logic         i_instr_addr_ma;
  logic         o_stall;
  logic [63:0]  o_cache_addr;
  logic         o_cache_write_en;
  logic [511:0] o_cache_block;
  logic         o_mem_req;
  logic [63:0]  o_mem_addr;
  logic         i_mem_req_ready;
  logic         i_mem_data_valid;
  logic [63:0]  i_mem_data;
  logic         o_bus_err;

  int tests = 0;
  int fails = 0;
  int wcnt;
  int wcyc;
  int ecnt;
  int ecyc;
  logic [511:0] exp_blk;

  icache_refill_ctrl #(
    .ADDR_WIDTH    (64),
    .BLOCK_WIDTH   (512),
    .MEM_DATA_W    (64),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk             (clk),
    .arstn           (arstn),
    .i_fetch_req     (i_fetch_req),
    .i_instr_addr    (i_instr_addr),
    .i_hit           (i_hit),
    .i_instr_addr_ma (i_instr_addr_ma),
    .o_stall         (o_stall),
    .o_cache_addr    (o_cache_addr),
    .o_cache_write_en(o_cache_write_en),
    .o_cache_block   (o_cache_block),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_data_valid(i_mem_data_valid),
    .i_mem_data      (i_mem_data),
    .o_bus_err       (o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_blk[i*64 +: 64] = 64'(i);

    arstn = 1'b0; i_fetch_req = 1'b1; i_hit = 1'b0; i_instr_addr_ma = 1'b0;
    i_instr_addr = 64'h1044; i_mem_req_ready = 1'b0; i_mem_data_valid = 1'b0; i_mem_data = '0;

    // Reset: stall masked, cache address follows fetch, outputs cleared
    tick(); #1;
    check("rst_stall", o_stall, 0);
    check("rst_cache_addr", o_cache_addr, 64'h1044);
    tick(); #1;
    check("rst_mem_req", o_mem_req, 0);
    check("rst_write_en", o_cache_write_en, 0);
    check("rst_bus_err", o_bus_err, 0);
    check("rst_block", o_cache_block, 0);

    // Hit
    tick(); arstn = 1'b1; i_hit = 1'b1; i_instr_addr = 64'h2000; #1;
    check("hit_stall", o_stall, 0);
    check("hit_cache_addr", o_cache_addr, 64'h2000);
    tick(); #1;
    check("hit_no_req", o_mem_req, 0);

    // Miss at 0x1044, ready and valid every cycle
    tick(); i_hit = 1'b0; i_instr_addr = 64'h1044; i_mem_req_ready = 1'b1; #1;
    check("miss_stall_comb", o_stall, 1);
    check("miss_req_not_yet", o_mem_req, 0);
    wcnt = 0; wcyc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      i_mem_data_valid = (c >= 2 && c <= 9);
      i_mem_data = 64'(c - 2);
      if (c >= 11) i_hit = 1'b1;
      #1;
      if (o_cache_write_en) begin wcnt++; wcyc = c; end
      if (c == 1) begin
        check("miss_mem_req", o_mem_req, 1);
        check("miss_mem_addr", o_mem_addr, 64'h1040);
        check("miss_cache_addr", o_cache_addr, 64'h1040);
      end
      if (c == 10) begin
        check("miss_blk_lo", o_cache_block[63:0], 64'h0);
        check("miss_blk_hi", o_cache_block[511:448], 64'h7);
        check("miss_blk", o_cache_block, exp_blk);
        check("miss_write_addr", o_cache_addr, 64'h1040);
        check("miss_stall_write", o_stall, 1);
      end
      if (c == 11) check("miss_stall_drop", o_stall, 0);
    end
    check("miss_write_count", wcnt, 1);
    check("miss_write_cycle", wcyc, 10);

    // Gapped: ready after 4 REQ cycles, valid every 3rd cycle (early ones during REQ)
    tick(); i_hit = 1'b0; i_instr_addr = 64'h2A38; i_mem_req_ready = 1'b0; i_mem_data_valid = 1'b0; #1;
    check("gap_stall_comb", o_stall, 1);
    wcnt = 0; wcyc = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      i_mem_req_ready = (c >= 5);
      i_mem_data_valid = (c % 3 == 2);
      i_mem_data = (c < 6) ? 64'hBAD0 : 64'((c - 8) / 3);
      i_hit = (c >= 31);
      #1;
      if (o_cache_write_en) begin wcnt++; wcyc = c; end
      if (c == 4) begin
        check("gap_req_held", o_mem_req, 1);
        check("gap_req_addr", o_mem_addr, 64'h2A00);
      end
      if (c == 6) check("gap_req_dropped", o_mem_req, 0);
      if (c == 29) check("gap_stall_last_beat", o_stall, 1);
      if (c == 30) check("gap_blk", o_cache_block, exp_blk);
      if (c == 31) check("gap_stall_drop", o_stall, 0);
      if (c == 32) check("gap_blk_hold", o_cache_block, exp_blk);
    end
    check("gap_write_count", wcnt, 1);
    check("gap_write_cycle", wcyc, 30);

    // Misaligned miss
    tick(); i_mem_data_valid = 1'b0; i_mem_req_ready = 1'b0; i_hit = 1'b0;
    i_instr_addr_ma = 1'b1; i_instr_addr = 64'h1046; #1;
    check("ma_stall", o_stall, 0);
    check("ma_cache_addr", o_cache_addr, 64'h1046);
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      check("ma_no_req", o_mem_req, 0);
    end
    tick(); i_instr_addr_ma = 1'b0; i_fetch_req = 1'b0;

    // Reset during FILL after 3 beats
    tick(); i_fetch_req = 1'b1; i_instr_addr = 64'h3008; i_mem_req_ready = 1'b1; #1;
    check("rf_stall_comb", o_stall, 1);
    wcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      i_mem_data_valid = (c >= 2);
      i_mem_data = 64'h100 + 64'(c);
      arstn = (c != 5);
      i_fetch_req = (c <= 5);
      i_instr_addr = (c >= 6) ? 64'h5550 : 64'h3008;
      #1;
      if (o_cache_write_en) wcnt++;
      if (c == 4) check("rf_stall_fill", o_stall, 1);
      if (c == 5) begin
        check("rf_stall_in_reset", o_stall, 0);
        check("rf_addr_in_reset", o_cache_addr, 64'h3008);
      end
      if (c == 6) begin
        check("rf_idle_stall", o_stall, 0);
        check("rf_idle_req", o_mem_req, 0);
        check("rf_idle_addr", o_cache_addr, 64'h5550);
        check("rf_blk_cleared", o_cache_block, 0);
      end
      if (c == 12) check("rf_beats_ignored", o_cache_block, 0);
    end
    check("rf_no_write", wcnt, 0);

    // Memory never accepts the request
    tick(); i_mem_data_valid = 1'b0; i_mem_req_ready = 1'b0; i_fetch_req = 1'b1;
    i_hit = 1'b0; i_instr_addr = 64'h4010; #1;
    check("to_stall_comb", o_stall, 1);
    wcnt = 0; ecnt = 0; ecyc = 0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    for (int c = 1; c <= 20; c++) begin
      tick();
      i_fetch_req = (c <= 16);
      #1;
      if (o_bus_err) begin ecnt++; ecyc = c; end
      if (o_cache_write_en) wcnt++;
      if (c == 16) check("to_req_at_expiry", o_mem_req, 1);
      if (c == 17) begin
        check("to_idle_stall", o_stall, 0);
        check("to_idle_req", o_mem_req, 0);
      end
    end
    check("to_err_count", ecnt, 1);
    check("to_err_cycle", ecyc, 16);
    check("to_no_write", wcnt, 0);
`else
    for (int c = 1; c <= 20; c++) begin
      tick(); #1;
      if (o_bus_err) begin ecnt++; ecyc = c; end
      if (o_cache_write_en) wcnt++;
      if (c == 20) begin
        check("wait_req_held", o_mem_req, 1);
        check("wait_stall", o_stall, 1);
        check("wait_addr", o_mem_addr, 64'h4000);
      end
    end
    check("wait_no_err", ecnt, 0);
    check("wait_no_write", wcnt, 0);
    tick(); arstn = 1'b0; i_fetch_req = 1'b0;
    tick(); arstn = 1'b1; #1;
    check("wait_abort_req", o_mem_req, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
